// File: rtl/frv_pipeline_lsu_writeback.sv
// -----------------------------------------------------------------------------
// frv_pipeline_lsu_writeback
//   Writeback stage. Consumes the s4 micro-op and waits for the memory/MMIO
//   response of any load/store. It aligns and extends load data, raises
//   access-fault traps and produces one registered GPR write plus one
//   retire/trap pulse per instruction. Responses that belong to flushed
//   loads/stores are counted and thrown away.
//
//   Optional feature: define FRV_WB_INSTRET_EN to add a 64-bit retired
//   instruction counter on output instret.
//
// Ports
//   g_clk, g_resetn           clock, asynchronous active-low reset
//   flush                     kill the instruction currently in s4
//   s4_rd/opr_a/opr_b/uop/fu/trap/valid   s4 micro-op
//   s4_busy                   s4 cannot accept new input (comb)
//   dmem_recv/error/rdata     data-memory response
//   mmio_recv/error/rdata     MMIO response
//   gpr_wen/wide/rd/wdata/wdata_hi        registered GPR write
//   retire, trap_valid/cause/mtval        registered completion pulse
//   fwd_s4_rd, fwd_s4_load_wait           forwarding hints (comb)
//   instret                   retired count (FRV_WB_INSTRET_EN only)
// -----------------------------------------------------------------------------
module frv_pipeline_lsu_writeback #(
    parameter logic [5:0]  TRAP_LDACCESS = 6'd5,
    parameter logic [5:0]  TRAP_STACCESS = 6'd7,
    parameter int unsigned DROP_W        = 2,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned OP            = 4,
    parameter int unsigned FU            = 7
) (
    input  logic            g_clk,
    input  logic            g_resetn,
`ifdef FRV_WB_INSTRET_EN
    output logic [63:0]     instret,
`endif
    input  logic            flush,
    input  logic [4:0]      s4_rd,
    input  logic [XLEN-1:0] s4_opr_a,
    input  logic [XLEN-1:0] s4_opr_b,
    input  logic [OP:0]     s4_uop,
    input  logic [FU:0]     s4_fu,
    input  logic            s4_trap,
    input  logic            s4_valid,
    output logic            s4_busy,
    input  logic            dmem_recv,
    input  logic            dmem_error,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            mmio_recv,
    input  logic            mmio_error,
    input  logic [XLEN-1:0] mmio_rdata,
    output logic            gpr_wen,
    output logic            gpr_wide,
    output logic [4:0]      gpr_rd,
    output logic [XLEN-1:0] gpr_wdata,
    output logic [XLEN-1:0] gpr_wdata_hi,
    output logic            retire,
    output logic            trap_valid,
    output logic [5:0]      trap_cause,
    output logic [XLEN-1:0] trap_mtval,
    output logic [4:0]      fwd_s4_rd,
    output logic            fwd_s4_load_wait
);

    // Shared pipeline encodings
    localparam int unsigned OP_W       = OP + 1;
    localparam int unsigned P_FU_MUL   = 1;
    localparam int unsigned P_FU_LSU   = 2;
    localparam int unsigned P_FU_BIT   = 5;
    localparam int unsigned LSU_LOAD   = 4;
    localparam int unsigned LSU_SIGNED = 0;
    localparam int unsigned MMIO_BIT   = 4;
    localparam logic [1:0]  LSU_BYTE   = 2'b01;
    localparam logic [1:0]  LSU_HALF   = 2'b10;
    localparam logic [OP:0] MUL_MADD   = OP_W'(5'b11000);
    localparam logic [OP:0] MUL_MSUB   = OP_W'(5'b11001);
    localparam logic [OP:0] MUL_MACC   = OP_W'(5'b11010);
    localparam logic [OP:0] MUL_MMUL   = OP_W'(5'b11011);
    localparam logic [OP:0] BIT_RORW   = OP_W'(5'b01010);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_nxt;

    logic              lsu_op;
    logic              sel_mmio;
    logic              rsp;
    logic              rsp_err;
    logic [XLEN-1:0]   rsp_data;
    logic [XLEN-1:0]   rsp_shift;
    logic [XLEN-1:0]   load_data;
    logic              consume;
    logic              drop_inc;
    logic              drop_dec;
    logic              wide_op;
    logic              unused_fu;

    logic              gpr_wen_nxt;
    logic              gpr_wide_nxt;
    logic [4:0]        gpr_rd_nxt;
    logic [XLEN-1:0]   gpr_wdata_nxt;
    logic [XLEN-1:0]   gpr_wdata_hi_nxt;
    logic              retire_nxt;
    logic              trap_valid_nxt;
    logic [5:0]        trap_cause_nxt;
    logic [XLEN-1:0]   trap_mtval_nxt;

    assign unused_fu = ^s4_fu;

    // Response path selected by the MMIO flag carried in opr_a
    assign lsu_op   = s4_valid && s4_fu[P_FU_LSU] && !s4_trap;
    assign sel_mmio = s4_opr_a[MMIO_BIT];
    assign rsp      = sel_mmio ? mmio_recv  : dmem_recv;
    assign rsp_err  = sel_mmio ? mmio_error : dmem_error;
    assign rsp_data = sel_mmio ? mmio_rdata : dmem_rdata;

    // Stale responses of flushed ops are drained before s4 may consume one
    assign consume  = lsu_op && rsp && (drop_cnt == '0);
    assign drop_dec = (drop_cnt != '0) && (dmem_recv || mmio_recv);
    assign drop_inc = flush && lsu_op && !consume;

    assign wide_op = (s4_fu[P_FU_MUL] && (s4_uop inside {MUL_MADD, MUL_MSUB, MUL_MACC, MUL_MMUL}))
                   || (s4_fu[P_FU_BIT] && (s4_uop == BIT_RORW));

    // Load alignment and extension
    assign rsp_shift = rsp_data >> {s4_opr_b[1:0], 3'b000};
    always_comb begin
        load_data = rsp_shift;
        case (s4_uop[2:1])
            LSU_BYTE: load_data = s4_uop[LSU_SIGNED]
                                ? {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]}
                                : {{(XLEN-8){1'b0}}, rsp_shift[7:0]};
            LSU_HALF: load_data = s4_uop[LSU_SIGNED]
                                ? {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]}
                                : {{(XLEN-16){1'b0}}, rsp_shift[15:0]};
            default:  load_data = rsp_shift;
        endcase
    end

    // Combinational stage status, forced low while in reset
    assign s4_busy          = g_resetn && lsu_op && !consume;
    assign fwd_s4_rd        = (g_resetn && s4_valid) ? s4_rd : 5'd0;
    assign fwd_s4_load_wait = g_resetn && lsu_op && s4_uop[LSU_LOAD];

    // Next state, drop counter and completion outputs
    always_comb begin
        state_nxt        = state;
        drop_nxt         = drop_cnt;
        gpr_wen_nxt      = 1'b0;
        gpr_wide_nxt     = 1'b0;
        gpr_rd_nxt       = 5'd0;
        gpr_wdata_nxt    = '0;
        gpr_wdata_hi_nxt = '0;
        retire_nxt       = 1'b0;
        trap_valid_nxt   = 1'b0;
        trap_cause_nxt   = 6'd0;
        trap_mtval_nxt   = '0;

        case (state)
            RUN:     if (lsu_op && !consume && !flush) state_nxt = WAIT;
            WAIT:    if (!lsu_op || consume || flush)  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        if (drop_inc && !drop_dec && (drop_cnt != DROP_MAX)) begin
            drop_nxt = drop_cnt + DROP_W'(1);
        end else if (drop_dec && !drop_inc) begin
            drop_nxt = drop_cnt - DROP_W'(1);
        end

        if (s4_valid && !flush) begin
            if (s4_trap) begin
                trap_valid_nxt = 1'b1;
                trap_cause_nxt = {1'b0, s4_rd};
            end else if (s4_fu[P_FU_LSU]) begin
                if (consume && rsp_err) begin
                    trap_valid_nxt = 1'b1;
                    trap_cause_nxt = s4_uop[LSU_LOAD] ? TRAP_LDACCESS : TRAP_STACCESS;
                    trap_mtval_nxt = s4_opr_b;
                end else if (consume) begin
                    retire_nxt    = 1'b1;
                    gpr_wen_nxt   = s4_uop[LSU_LOAD] && (s4_rd != 5'd0);
                    gpr_rd_nxt    = s4_rd;
                    gpr_wdata_nxt = load_data;
                end
            end else begin
                retire_nxt    = 1'b1;
                gpr_wen_nxt   = (s4_rd != 5'd0);
                gpr_wide_nxt  = (s4_rd != 5'd0) && wide_op;
                gpr_rd_nxt    = s4_rd;
                gpr_wdata_nxt = s4_opr_a;
                if (wide_op) gpr_wdata_hi_nxt = s4_opr_b;
            end
        end
    end

    // State and drop counter registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state    <= RUN;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // Registered writeback and completion outputs
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            gpr_wen      <= 1'b0;
            gpr_wide     <= 1'b0;
            gpr_rd       <= 5'd0;
            gpr_wdata    <= '0;
            gpr_wdata_hi <= '0;
            retire       <= 1'b0;
            trap_valid   <= 1'b0;
            trap_cause   <= 6'd0;
            trap_mtval   <= '0;
        end else begin
            gpr_wen      <= gpr_wen_nxt;
            gpr_wide     <= gpr_wide_nxt;
            gpr_rd       <= gpr_rd_nxt;
            gpr_wdata    <= gpr_wdata_nxt;
            gpr_wdata_hi <= gpr_wdata_hi_nxt;
            retire       <= retire_nxt;
            trap_valid   <= trap_valid_nxt;
            trap_cause   <= trap_cause_nxt;
            trap_mtval   <= trap_mtval_nxt;
        end
    end

`ifdef FRV_WB_INSTRET_EN
    // Counts the cycle after each retire pulse
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            instret <= 64'd0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`else
`endif

    // More flushed-but-outstanding ops than the counter can hold
    drop_overflow: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(drop_inc && !drop_dec && (drop_cnt == DROP_MAX)));

endmodule

// File: tb/tb_frv_pipeline_lsu_writeback.sv
module tb_frv_pipeline_lsu_writeback;

    localparam logic [7:0] FU_ALU = 8'h01;
    localparam logic [7:0] FU_MUL = 8'h02;
    localparam logic [7:0] FU_LSU = 8'h04;
    localparam logic [7:0] FU_BIT = 8'h20;
    localparam logic [4:0] UOP_LB  = 5'b10011;
    localparam logic [4:0] UOP_LHU = 5'b10100;
    localparam logic [4:0] UOP_LW  = 5'b10110;
    localparam logic [4:0] UOP_SW  = 5'b01110;
    localparam logic [4:0] UOP_MMUL = 5'b11011;
    localparam logic [4:0] UOP_RORW = 5'b01010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic [4:0]  s4_rd;
    logic [31:0] s4_opr_a, s4_opr_b;
    logic [4:0]  s4_uop;
    logic [7:0]  s4_fu;
    logic        s4_trap, s4_valid, s4_busy;
    logic        dmem_recv, dmem_error, mmio_recv, mmio_error;
    logic [31:0] dmem_rdata, mmio_rdata;
    logic        gpr_wen, gpr_wide, retire, trap_valid, fwd_s4_load_wait;
    logic [4:0]  gpr_rd, fwd_s4_rd;
    logic [31:0] gpr_wdata, gpr_wdata_hi, trap_mtval;
    logic [5:0]  trap_cause;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        wen;
        logic        wide;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic        ret;
        logic        trap;
        logic [5:0]  cause;
        logic [31:0] mtval;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    frv_pipeline_lsu_writeback dut (
        .g_clk(clk), .g_resetn(rst_n), .flush(flush),
        .s4_rd(s4_rd), .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b),
        .s4_uop(s4_uop), .s4_fu(s4_fu), .s4_trap(s4_trap),
        .s4_valid(s4_valid), .s4_busy(s4_busy),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .mmio_recv(mmio_recv), .mmio_error(mmio_error), .mmio_rdata(mmio_rdata),
        .gpr_wen(gpr_wen), .gpr_wide(gpr_wide), .gpr_rd(gpr_rd),
        .gpr_wdata(gpr_wdata), .gpr_wdata_hi(gpr_wdata_hi),
        .retire(retire), .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_mtval(trap_mtval), .fwd_s4_rd(fwd_s4_rd),
        .fwd_s4_load_wait(fwd_s4_load_wait)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_ret(input logic wen, input logic wide, input logic [4:0] rd,
                                    input logic [31:0] wd, input logic [31:0] hi);
        exp_t e;
        e = '0;
        e.wen = wen; e.wide = wide; e.rd = rd; e.wdata = wd; e.hi = hi; e.ret = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk_trap(input logic [5:0] cause, input logic [31:0] mtval);
        exp_t e;
        e = '0;
        e.trap = 1'b1; e.cause = cause; e.mtval = mtval;
        return e;
    endfunction

    task automatic push(input string name, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic set_s4(input logic [7:0] fu, input logic [4:0] uop, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic trap);
        s4_valid = 1'b1; s4_fu = fu; s4_uop = uop; s4_rd = rd;
        s4_opr_a = a; s4_opr_b = b; s4_trap = trap;
    endtask

    task automatic set_rsp(input logic dm, input logic mm, input logic err, input logic [31:0] data);
        dmem_recv = dm; mmio_recv = mm;
        dmem_error = dm & err; mmio_error = mm & err;
        dmem_rdata = data; mmio_rdata = data;
    endtask

    task automatic idle();
        s4_valid = 1'b0; s4_fu = '0; s4_uop = '0; s4_rd = '0;
        s4_opr_a = '0; s4_opr_b = '0; s4_trap = 1'b0; flush = 1'b0;
        set_rsp(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: every completion pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && (gpr_wen || retire || trap_valid)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: wen=%0b rd=%0d wdata=%h ret=%0b trap=%0b cause=%0d",
                         gpr_wen, gpr_rd, gpr_wdata, retire, trap_valid, trap_cause);
            end else begin
                exp_t  e;
                string n;
                logic  bad;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                bad = (gpr_wen !== e.wen) || (gpr_wide !== e.wide) ||
                      (retire !== e.ret) || (trap_valid !== e.trap);
                if (e.wen && ((gpr_rd !== e.rd) || (gpr_wdata !== e.wdata))) bad = 1'b1;
                if (e.wide && (gpr_wdata_hi !== e.hi)) bad = 1'b1;
                if (e.trap && ((trap_cause !== e.cause) || (trap_mtval !== e.mtval))) bad = 1'b1;
                if (bad) begin
                    errors++;
                    $display("FAIL wb_%s: got wen=%0b wide=%0b rd=%0d wd=%h hi=%h ret=%0b trap=%0b cause=%0d mtval=%h; want wen=%0b wide=%0b rd=%0d wd=%h hi=%h ret=%0b trap=%0b cause=%0d mtval=%h",
                             n, gpr_wen, gpr_wide, gpr_rd, gpr_wdata, gpr_wdata_hi, retire,
                             trap_valid, trap_cause, trap_mtval, e.wen, e.wide, e.rd, e.wdata,
                             e.hi, e.ret, e.trap, e.cause, e.mtval);
                end
            end
        end
    end

    initial begin
        idle();
        #1;
        chk("reset_gpr_wen", 32'(gpr_wen), 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        chk("reset_trap_valid", 32'(trap_valid), 32'd0);
        chk("reset_trap_cause", 32'(trap_cause), 32'd0);
        chk("reset_gpr_wdata", gpr_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_busy", 32'(s4_busy), 32'd0);

        // ALU op
        @(negedge clk);
        set_s4(FU_ALU, 5'd0, 5'd5, 32'h1234, 32'h0, 1'b0);
        push("alu", mk_ret(1'b1, 1'b0, 5'd5, 32'h1234, 32'h0));
        #1 chk("alu_busy", 32'(s4_busy), 32'd0);
        chk("alu_fwd_rd", 32'(fwd_s4_rd), 32'd5);

        // Wide multiply, then a wide-capable op to x0
        @(negedge clk);
        set_s4(FU_MUL, UOP_MMUL, 5'd6, 32'h11, 32'h22, 1'b0);
        push("mul_wide", mk_ret(1'b1, 1'b1, 5'd6, 32'h11, 32'h22));
        @(negedge clk);
        set_s4(FU_BIT, UOP_RORW, 5'd0, 32'h33, 32'h44, 1'b0);
        push("rorw_x0", mk_ret(1'b0, 1'b0, 5'd0, 32'h0, 32'h0));

        // Signed byte load, response 3 cycles later
        @(negedge clk);
        set_s4(FU_LSU, UOP_LB, 5'd7, 32'h1, 32'h0000_1003, 1'b0);
        #1 chk("lb_load_wait", 32'(fwd_s4_load_wait), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk($sformatf("lb_busy_%0d", i), 32'(s4_busy), 32'd1);
        end
        @(negedge clk);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h80FF_FF00);
        push("lb_signed", mk_ret(1'b1, 1'b0, 5'd7, 32'hFFFF_FF80, 32'h0));
        #1 chk("lb_busy_rsp", 32'(s4_busy), 32'd0);

        // Unsigned half load, immediate response
        @(negedge clk);
        set_s4(FU_LSU, UOP_LHU, 5'd8, 32'h3, 32'h0000_2002, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'hBEEF_1234);
        push("lhu", mk_ret(1'b1, 1'b0, 5'd8, 32'h0000_BEEF, 32'h0));
        #1 chk("lhu_busy", 32'(s4_busy), 32'd0);

        // Store access fault
        @(negedge clk);
        set_s4(FU_LSU, UOP_SW, 5'd0, 32'hF, 32'h4000_0010, 1'b0);
        set_rsp(1'b0, 1'b0, 1'b0, 32'h0);
        #1 chk("sw_busy", 32'(s4_busy), 32'd1);
        @(negedge clk);
        set_rsp(1'b1, 1'b0, 1'b1, 32'h0);
        push("sw_fault", mk_trap(6'd7, 32'h4000_0010));

        // MMIO load fault; a dmem response must not complete it
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd9, 32'h1F, 32'h8000_0004, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h1111_1111);
        #1 chk("mmio_ignore_dmem", 32'(s4_busy), 32'd1);
        @(negedge clk);
        set_rsp(1'b0, 1'b1, 1'b1, 32'h0);
        push("lw_mmio_fault", mk_trap(6'd5, 32'h8000_0004));

        // Flush a waiting load; its response is dropped from the next load
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd11, 32'hF, 32'h100, 1'b0);
        set_rsp(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        set_s4(FU_LSU, UOP_LW, 5'd12, 32'hF, 32'h104, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        #1 chk("drop_busy", 32'(s4_busy), 32'd1);
        @(negedge clk);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h1122_3344);
        push("after_drop", mk_ret(1'b1, 1'b0, 5'd12, 32'h1122_3344, 32'h0));
        #1 chk("after_drop_busy", 32'(s4_busy), 32'd0);

        // MMIO load answered in its first cycle
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd10, 32'h1F, 32'h8000_0000, 1'b0);
        set_rsp(1'b0, 1'b1, 1'b0, 32'hCAFE_0001);
        push("mmio_lw", mk_ret(1'b1, 1'b0, 5'd10, 32'hCAFE_0001, 32'h0));
        #1 chk("mmio_lw_busy", 32'(s4_busy), 32'd0);

        // Upstream trap
        @(negedge clk);
        set_s4(FU_ALU, 5'd0, 5'd2, 32'h5, 32'h6, 1'b1);
        set_rsp(1'b0, 1'b0, 1'b0, 32'h0);
        push("upstream_trap", mk_trap(6'd2, 32'h0));

        // Flushed ALU op and flush together with a consumed response
        @(negedge clk);
        set_s4(FU_ALU, 5'd0, 5'd13, 32'h99, 32'h0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd14, 32'hF, 32'h4, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h7777_7777);
        @(negedge clk);
        flush = 1'b0;
        set_s4(FU_LSU, UOP_LW, 5'd15, 32'hF, 32'h8, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h55AA_55AA);
        push("no_drop_inc", mk_ret(1'b1, 1'b0, 5'd15, 32'h55AA_55AA, 32'h0));
        #1 chk("no_drop_inc_busy", 32'(s4_busy), 32'd0);

        // Reset with drop_cnt=1 and a load outstanding
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd16, 32'hF, 32'h10, 1'b0);
        set_rsp(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        set_s4(FU_ALU, 5'd0, 5'd3, 32'h77, 32'h0, 1'b0);
        push("pre_reset_alu", mk_ret(1'b1, 1'b0, 5'd3, 32'h77, 32'h0));
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd17, 32'hF, 32'h20, 1'b0);
        #2 chk("pre_reset_wen", 32'(gpr_wen), 32'd1);
        chk("pre_reset_busy", 32'(s4_busy), 32'd1);
        rst_n = 1'b0;
        #1 chk("async_rst_wen", 32'(gpr_wen), 32'd0);
        chk("async_rst_retire", 32'(retire), 32'd0);
        chk("async_rst_wdata", gpr_wdata, 32'd0);
        chk("async_rst_busy", 32'(s4_busy), 32'd0);
        chk("async_rst_fwd_rd", 32'(fwd_s4_rd), 32'd0);
        chk("async_rst_load_wait", 32'(fwd_s4_load_wait), 32'd0);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_s4(FU_LSU, UOP_LW, 5'd18, 32'hF, 32'h30, 1'b0);
        set_rsp(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
        push("post_reset_lw", mk_ret(1'b1, 1'b0, 5'd18, 32'h0BAD_F00D, 32'h0));
        #1 chk("post_reset_busy", 32'(s4_busy), 32'd0);

        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frv_pipeline_lsu_writeback.md
# frv_pipeline_lsu_writeback

Writeback-side consumer of the memory stage. Accepts the s4 micro-op, waits for the data-memory or MMIO response of any granted load/store, aligns and sign-extends load data, and raises load/store access-fault traps. Produces one registered GPR write (narrow or wide) and one retire/trap pulse per instruction. Tracks responses still outstanding for flushed loads/stores and discards them.

## Interface
Parameters (width constants XL, OP, FU, XLEN, LSU_*, MUL_*, BIT_RORW, P_FU_* come from frv_common.vh):
- TRAP_LDACCESS, 6'd5, cause code for a load access fault
- TRAP_STACCESS, 6'd7, cause code for a store access fault
- DROP_W, 2, width of the discarded-response counter

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  asynchronous, active-low reset
- flush  in  1  kill the instruction currently in s4
- s4_rd  in  5  destination reg, or trap cause when s4_trap=1
- s4_opr_a  in  XLEN  result; for LSU ops {27'b0, mmio, strb[3:0]}
- s4_opr_b  in  XLEN  high result word; for LSU ops the byte address
- s4_uop  in  OP+1  micro-op
- s4_fu  in  FU+1  functional unit one-hot
- s4_trap  in  1  instruction already trapped upstream
- s4_valid  in  1  s4 inputs valid
- s4_busy  out  1  stage cannot accept new s4 input
- dmem_recv  in  1  data-memory response valid, one cycle
- dmem_error  in  1  response error, qualified by dmem_recv
- dmem_rdata  in  XLEN  response data
- mmio_recv  in  1  MMIO response valid, one cycle
- mmio_error  in  1  MMIO error, qualified by mmio_recv
- mmio_rdata  in  XLEN  MMIO read data
- gpr_wen  out  1  GPR write enable
- gpr_wide  out  1  write gpr_rd and gpr_rd|1
- gpr_rd  out  5  destination
- gpr_wdata  out  XLEN  low write data
- gpr_wdata_hi  out  XLEN  high write data
- retire  out  1  instruction completed without trap
- trap_valid  out  1  trap taken
- trap_cause  out  6  trap cause
- trap_mtval  out  XLEN  faulting address, or 0
- fwd_s4_rd  out  5  s4_rd while s4_valid, else 0
- fwd_s4_load_wait  out  1  s4 holds a load whose data is not yet written back

## Operation
- States: RUN (no LSU op waiting), WAIT (LSU op at head, response pending). Reset -> RUN.
- Response selection: response = mmio_recv if s4_opr_a[4] else dmem_recv; the data and error ports follow the same selection.
- Non-LSU, no trap: completes in the cycle presented; gpr_wen = (s4_rd != 0); wdata = s4_opr_a. Wide when fu_mul with uop in {MUL_MADD, MUL_MSUB, MUL_MACC, MUL_MMUL}, or fu_bit with BIT_RORW; then wdata_hi = s4_opr_b.
- s4_trap=1: completes immediately; trap_cause = {1'b0, s4_rd}; trap_mtval = 0; no GPR write.
- LSU op: s4_busy=1 until a response is consumed; a response in the first cycle completes that cycle (RUN stays RUN). Otherwise RUN->WAIT, and WAIT->RUN on the response.
- Response with error: trap, cause TRAP_LDACCESS or TRAP_STACCESS; mtval = s4_opr_b.
- Load success: shift data right by 8*addr[1:0]. Byte/half ops zero- or sign-extend (LSU_SIGNED); word ops pass through. Write to rd if rd != 0.
- Store success: retire only.
- Drop counter: a flush while an LSU op waits without a response increments drop_cnt. While drop_cnt != 0, each response is discarded and decrements it before any s4 op can consume a response.
- Simultaneous increment and decrement: no change. A flush in the same cycle as a consumed response does not increment; that instruction has no writeback and no trap. A flush of a non-LSU op discards it.
- drop_cnt saturates at 2^DROP_W-1; the upstream contract never exceeds it. Overflow is an assertion failure.

## Timing
- Completion in cycle N -> gpr_*, retire, trap_valid, trap_cause, trap_mtval registered, valid in N+1 for exactly one cycle.
- s4_busy, fwd_s4_rd, fwd_s4_load_wait are combinational.
- Reset (asynchronous) clears: state=RUN, drop_cnt=0, all registered outputs 0.
- If reset is asserted mid-WAIT, the pending response is lost. The environment must also reset memory.
- gpr_wen and trap_valid are never high in the same cycle. retire and trap_valid are mutually exclusive.

## Configuration
- FRV_WB_INSTRET_EN defined: adds output instret [63:0], reset 0, incremented by 1 in the cycle after each retire pulse, wraps at 2^64.
- FRV_WB_INSTRET_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- ALU op, rd=5, opr_a=0x1234, valid 1 cycle -> next cycle gpr_wen=1, rd=5, wdata=0x1234, retire=1; s4_busy stays 0.
- Signed byte load, addr=0x..03, dmem_rdata=0x80FF_FF00, response 3 cycles later -> s4_busy=1 for 3 cycles; then gpr_wdata=0xFFFF_FF80.
- Store, dmem_recv with dmem_error=1 -> trap_valid=1, trap_cause=7, trap_mtval=addr; gpr_wen=0.
- Load waiting, flush, then a new word load -> first response dropped (drop_cnt 1->0); second response written with correct data.
- Load with mmio bit set, mmio_rdata=0xCAFE_0001 arrives in the same cycle as s4_valid -> completes that cycle; gpr_wdata=0xCAFE_0001.
- Async reset asserted in WAIT with drop_cnt=1 -> all outputs 0 immediately; state RUN and drop_cnt=0 after release.
